// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if: requester (fetch/data) and memory signals of the CHIP-8 memory arbiter.
// Carries d_prot_err only when CHIP8_FONT_PROTECT_EN is defined.
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W      = 12,
  parameter int MAX_BURST_W = 4
);
  logic                   fetch_req;
  logic [ADDR_W-1:0]      fetch_addr;
  logic                   fetch_done;
  logic [15:0]            fetch_opcode;
  logic                   d_req;
  logic                   d_we;
  logic [ADDR_W-1:0]      d_addr;
  logic [MAX_BURST_W-1:0] d_len;
  logic [MAX_BURST_W-1:0] d_idx;
  logic [7:0]             d_wdata;
  logic [7:0]             d_rdata;
  logic                   d_rvalid;
  logic                   d_done;
`ifdef CHIP8_FONT_PROTECT_EN
  logic                   d_prot_err;
`endif
  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_W-1:0]      mem_address;
  logic [7:0]             mem_data_in;
  logic [7:0]             mem_data_out;
  modport slave (
    input  fetch_req, fetch_addr, d_req, d_we, d_addr, d_len, d_wdata, mem_data_out,
    output fetch_done, fetch_opcode, d_idx, d_rdata, d_rvalid, d_done,
`ifdef CHIP8_FONT_PROTECT_EN
    d_prot_err,
`endif
    mem_read, mem_write, mem_address, mem_data_in
  );
  modport master (
    output fetch_req, fetch_addr, d_req, d_we, d_addr, d_len, d_wdata, mem_data_out,
    input  fetch_done, fetch_opcode, d_idx, d_rdata, d_rvalid, d_done,
`ifdef CHIP8_FONT_PROTECT_EN
    d_prot_err,
`endif
    mem_read, mem_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: round-robin owner of the 4 KB CHIP-8 memory for opcode fetch and data bursts.
// Define CHIP8_FONT_PROTECT_EN to block writes to the font area 0x000..0x04F and report d_prot_err.
module chip8_mem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int MAX_BURST_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  chip8_mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, F_A0, F_A1, F_CAP, RD, WR, DONE} state_t;
  state_t                 state;
  logic                   lg_data;
  logic [7:0]             op_hi;
  logic [MAX_BURST_W-1:0] len;
  logic [ADDR_W-1:0]      nxt_addr;
  logic                   base_prot;
  logic                   next_prot;
  assign nxt_addr = bus.mem_address + 1'b1;
`ifdef CHIP8_FONT_PROTECT_EN
  logic perr;
  assign base_prot = bus.d_addr < ADDR_W'('h50);
  assign next_prot = nxt_addr < ADDR_W'('h50);
`else
  assign base_prot = 1'b0;
  assign next_prot = 1'b0;
`endif
  // Memory output is registered, so read data and write data pass straight through in their cycle.
  assign bus.d_rdata     = bus.d_rvalid ? bus.mem_data_out : '0;
  assign bus.mem_data_in = (state == WR) ? bus.d_wdata : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      lg_data          <= 1'b1;
      op_hi            <= '0;
      len              <= '0;
      bus.mem_read     <= 1'b1;
      bus.mem_write    <= 1'b0;
      bus.mem_address  <= '0;
      bus.fetch_done   <= 1'b0;
      bus.fetch_opcode <= '0;
      bus.d_done       <= 1'b0;
      bus.d_rvalid     <= 1'b0;
      bus.d_idx        <= '0;
`ifdef CHIP8_FONT_PROTECT_EN
      perr             <= 1'b0;
      bus.d_prot_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.fetch_req && (!bus.d_req || lg_data)) begin
            state           <= F_A0;
            lg_data         <= 1'b0;
            bus.mem_address <= bus.fetch_addr;
          end else if (bus.d_req) begin
            state           <= bus.d_we ? WR : RD;
            lg_data         <= 1'b1;
            len             <= bus.d_len;
            bus.d_idx       <= '0;
            bus.mem_address <= bus.d_addr;
            bus.mem_read    <= !bus.d_we || base_prot;
            bus.mem_write   <= bus.d_we && !base_prot;
`ifdef CHIP8_FONT_PROTECT_EN
            perr            <= bus.d_we && base_prot;
`endif
          end
        end
        F_A0: begin
          state           <= F_A1;
          bus.mem_address <= nxt_addr;
        end
        F_A1: begin
          state <= F_CAP;
          op_hi <= bus.mem_data_out;
        end
        F_CAP: begin
          state            <= DONE;
          bus.fetch_opcode <= {op_hi, bus.mem_data_out};
          bus.fetch_done   <= 1'b1;
        end
        RD: begin
          // Addresses run one cycle ahead of returned data; the over-read past the burst is harmless.
          bus.mem_address <= nxt_addr;
          if (bus.d_rvalid && bus.d_idx == len) begin
            state        <= DONE;
            bus.d_rvalid <= 1'b0;
            bus.d_done   <= 1'b1;
          end else begin
            bus.d_rvalid <= 1'b1;
            bus.d_idx    <= bus.d_rvalid ? bus.d_idx + 1'b1 : '0;
          end
        end
        WR: begin
          if (bus.d_idx == len) begin
            state          <= DONE;
            bus.d_done     <= 1'b1;
            bus.mem_read   <= 1'b1;
            bus.mem_write  <= 1'b0;
`ifdef CHIP8_FONT_PROTECT_EN
            bus.d_prot_err <= perr;
`endif
          end else begin
            bus.d_idx       <= bus.d_idx + 1'b1;
            bus.mem_address <= nxt_addr;
            bus.mem_read    <= next_prot;
            bus.mem_write   <= !next_prot;
`ifdef CHIP8_FONT_PROTECT_EN
            perr            <= perr || next_prot;
`endif
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.fetch_done <= 1'b0;
          bus.d_done     <= 1'b0;
`ifdef CHIP8_FONT_PROTECT_EN
          bus.d_prot_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: directed bench for chip8_mem_arbiter with a registered 4 KB memory model.
// Also covers font protection when CHIP8_FONT_PROTECT_EN is defined.
module tb_chip8_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_init = 1'b1;
  logic       mon = 1'b0;
  logic       rd_low = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mem [4096];
  logic [7:0] exq [$];
  always #5 clk = ~clk;
  chip8_mem_arbiter_if bus ();
  chip8_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.d_wdata = {bus.d_idx, bus.d_idx};
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h200] <= 8'h12;
      mem[12'h201] <= 8'h4E;
      mem[12'hFFF] <= 8'hA2;
      mem[12'h000] <= 8'hF0;
      mem[12'h00A] <= 8'hF0;
      mem[12'h00B] <= 8'h10;
      mem[12'h00C] <= 8'hF0;
      mem[12'h00D] <= 8'h80;
      mem[12'h00E] <= 8'hF0;
      mem[12'h04E] <= 8'h80;
      mem[12'h04F] <= 8'h80;
    end else begin
      if (!bus.mem_read) mem[bus.mem_address] <= bus.mem_data_in;
      bus.mem_data_out <= mem[bus.mem_address];
    end
  end
  always @(negedge clk) if (mon && rst_n && !bus.mem_read) rd_low <= 1'b1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_fetch(input logic [11:0] a, input logic [15:0] exp, input string tag);
    int n = 0;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = a;
    while (!bus.fetch_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_op"}, bus.fetch_opcode, exp);
    bus.fetch_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic rd_burst(input logic [11:0] a, input int l, input string tag);
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = a;
    bus.d_len = 4'(l);
    for (int c = 1; c <= l + 3; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= l + 2) begin
        chk({tag, "_rvalid"}, bus.d_rvalid, 1);
        chk({tag, "_idx"}, bus.d_idx, c - 2);
        chk({tag, "_rdata"}, bus.d_rdata, exq[c-2]);
      end else chk({tag, "_rvalid_off"}, bus.d_rvalid, 0);
      chk({tag, "_done"}, bus.d_done, 32'(c == l + 3));
    end
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic wr_burst(input logic [11:0] a, input int l, input string tag);
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = a;
    bus.d_len = 4'(l);
    for (int c = 1; c <= l + 2; c++) begin
      @(negedge clk);
      if (c <= l + 1) begin
        chk({tag, "_read"}, bus.mem_read, 0);
        chk({tag, "_write"}, bus.mem_write, 1);
        chk({tag, "_addr"}, bus.mem_address, a + 12'(c - 1));
        chk({tag, "_idx"}, bus.d_idx, c - 1);
        chk({tag, "_wdata"}, bus.mem_data_in, (c - 1) * 'h11);
      end else chk({tag, "_read_back_high"}, bus.mem_read, 1);
      chk({tag, "_done"}, bus.d_done, 32'(c == l + 2));
    end
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic pair(input string tag, input int exp_fc, input int exp_dc);
    int fc = 0;
    int dc = 0;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 12'h200;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 12'h00A;
    bus.d_len = 4'd0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.fetch_done) begin
        fc = n;
        bus.fetch_req = 1'b0;
      end
      if (bus.d_done) begin
        dc = n;
        bus.d_req = 1'b0;
      end
      if (fc != 0 && dc != 0) break;
    end
    bus.fetch_req = 1'b0;
    bus.d_req = 1'b0;
    chk({tag, "_fetch_cycle"}, fc, exp_fc);
    chk({tag, "_data_cycle"}, dc, exp_dc);
    @(negedge clk);
  endtask
  initial begin
    int dn;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", bus.mem_read, 1);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_data_in", bus.mem_data_in, 0);
    chk("rst_fetch_done", bus.fetch_done, 0);
    chk("rst_fetch_opcode", bus.fetch_opcode, 0);
    chk("rst_d_done", bus.d_done, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_d_idx", bus.d_idx, 0);
`ifdef CHIP8_FONT_PROTECT_EN
    chk("rst_d_prot_err", bus.d_prot_err, 0);
`endif
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    mon = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 12'h200;
    @(negedge clk);
    chk("f_addr_c1", bus.mem_address, 12'h200);
    chk("f_done_c1", bus.fetch_done, 0);
    @(negedge clk);
    chk("f_addr_c2", bus.mem_address, 12'h201);
    @(negedge clk);
    chk("f_done_c3", bus.fetch_done, 0);
    @(negedge clk);
    chk("f_done_c4", bus.fetch_done, 1);
    chk("f_opcode", bus.fetch_opcode, 16'h124E);
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("f_done_c5", bus.fetch_done, 0);
    chk("f_opcode_hold", bus.fetch_opcode, 16'h124E);
    mon = 1'b0;
    @(negedge clk);
    chk("f_read_never_low", rd_low, 0);
    do_fetch(12'hFFF, 16'hA2F0, "f_wrap");
    exq = '{8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0};
    rd_burst(12'h00A, 4, "rd_font");
    wr_burst(12'h300, 2, "wr300");
    chk("wr300_mem0", mem[12'h300], 8'h00);
    chk("wr300_mem1", mem[12'h301], 8'h11);
    chk("wr300_mem2", mem[12'h302], 8'h22);
    exq = '{8'h00, 8'h11, 8'h22};
    rd_burst(12'h300, 2, "rd300");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pair("rr_after_reset", 4, 8);
    do_fetch(12'h200, 16'h124E, "f_solo");
    pair("rr_alternate", 8, 3);
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 12'h310;
    bus.d_len = 4'd7;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_read", bus.mem_read, 1);
    chk("abort_mem_write", bus.mem_write, 0);
    chk("abort_mem_address", bus.mem_address, 0);
    chk("abort_d_idx", bus.d_idx, 0);
    chk("abort_mem_data_in", bus.mem_data_in, 0);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.d_done) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_mem_311", mem[12'h311], 8'h11);
    chk("abort_mem_312", mem[12'h312], 8'h00);
`ifdef CHIP8_FONT_PROTECT_EN
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 12'h04E;
    bus.d_len = 4'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("prot_addr", bus.mem_address, 12'h04E + 12'(c - 1));
        chk("prot_read", bus.mem_read, 32'(c <= 2));
        chk("prot_write", bus.mem_write, 32'(c > 2));
      end
      chk("prot_done", bus.d_done, 32'(c == 5));
      chk("prot_err", bus.d_prot_err, 32'(c == 5));
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("prot_err_clear", bus.d_prot_err, 0);
    chk("prot_mem_04e", mem[12'h04E], 8'h80);
    chk("prot_mem_04f", mem[12'h04F], 8'h80);
    chk("prot_mem_050", mem[12'h050], 8'h22);
    chk("prot_mem_051", mem[12'h051], 8'h33);
`else
    wr_burst(12'h04E, 0, "font_open");
    chk("font_open_mem", mem[12'h04E], 8'h00);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Sole master of the 4 KB CHIP-8 byte memory. Shares the memory between two requesters: the CPU instruction-fetch unit and the CPU data unit.
- Fetch unit needs a 2-byte big-endian opcode. Data unit needs burst reads (DXYN sprite rows, FX65) and burst writes (FX55, FX33).
- Sequences the memory's single-cycle registered read port.
- Keeps memory `read` high whenever no write is intended. The memory writes on every clock where `read` is low.

Parameters:
- ADDR_W, 12, memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- MAX_BURST_W, 4, width of burst length field; burst length = d_len+1, range 1..16.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  level; fetch opcode at fetch_addr; hold until fetch_done
- fetch_addr  in  12  opcode address (PC)
- fetch_done  out  1  one-cycle pulse; fetch_opcode valid this cycle
- fetch_opcode  out  16  {mem[A], mem[A+1]}; holds value until next fetch
- d_req  in  1  level; data burst request; hold until d_done
- d_we  in  1  1=burst write, 0=burst read; sampled with grant
- d_addr  in  12  burst base address (I register)
- d_len  in  4  burst length minus one
- d_idx  out  4  byte index k of the current write byte / returned read byte
- d_wdata  in  8  write byte for index d_idx (combinational from register file)
- d_rdata  out  8  read byte, valid when d_rvalid
- d_rvalid  out  1  read byte k valid, index on d_idx
- d_done  out  1  one-cycle pulse at burst end
- mem_read  out  1  to memory read; 1 except during write cycles
- mem_write  out  1  to memory write; 1 only during write cycles
- mem_address  out  12  to memory address
- mem_data_in  out  8  to memory write data
- mem_data_out  in  8  from memory; registered, valid one cycle after address issued

Behaviour:
- Reset (async, any state): state=IDLE; mem_read=1, mem_write=0, mem_address=0, mem_data_in=0; fetch_done=0, fetch_opcode=0, d_done=0, d_rvalid=0, d_rdata=0, d_idx=0; last_grant=DATA.
  - A reset mid-burst aborts the burst. No done pulse is produced. Partially written bytes remain in memory.
- FSM states: IDLE, F_A0, F_A1, F_CAP, RD, WR, DONE.
- IDLE: grant only from IDLE.
  - If both requests are high, round-robin grants the requester not equal to last_grant. Reset value last_grant=DATA, so fetch wins first.
  - On grant, latch address, d_we, d_len and update last_grant.
- Fetch timing (cycle 0 = grant edge):
  - Cycle 1 F_A0: mem_address=A.
  - Cycle 2 F_A1: mem_address=A+1 (wraps 0xFFF→0x000); capture mem_data_out as high byte at end of cycle.
  - Cycle 3 F_CAP: capture low byte.
  - Cycle 4 DONE: fetch_done=1 with opcode valid.
- Read burst, length L:
  - Cycles 1..L: state RD, mem_address=base+k for k=0..L-1, with wrap.
  - Cycles 2..L+1: d_rvalid=1, d_rdata=mem_data_out, d_idx=k.
  - Cycle L+2: DONE, d_done=1.
- Write burst, length L:
  - Cycles 1..L: state WR, mem_read=0, mem_write=1, mem_address=base+k, d_idx=k, mem_data_in=d_wdata.
  - Cycle L+1: DONE, d_done=1.
- DONE: lasts exactly one cycle and never grants. Requester drops req in the cycle it sees done. The next cycle is IDLE, and req is re-sampled there.
- No preemption: the granted transaction always completes.
- mem_read=1 in every state except WR.
- Request inputs and d_we/d_addr/d_len changing after grant are ignored.

Optional Feature:
- Macro CHIP8_FONT_PROTECT_EN.
- Defined: adds output d_prot_err (1 bit, reset 0).
  - Any write-burst byte whose address is 0x000..0x04F (font area) is suppressed: mem_read stays 1, mem_write 0 for that cycle.
  - d_prot_err pulses high with that burst's d_done.
  - Other bytes of the same burst are written normally.
- Undefined: port absent; all addresses writable.

Test Plan:
- Reset, memory 0x200=0x12, 0x201=0x4E; fetch_req with fetch_addr=0x200 → fetch_done high in cycle 4, fetch_opcode=0x124E; mem_read never low.
- fetch_addr=0xFFF, mem[0xFFF]=0xA2, mem[0x000]=0xF0 → fetch_opcode=0xA2F0 (address wrap).
- Read burst d_addr=0x00A, d_len=4 → d_rvalid in cycles 2..6, d_rdata=F0,10,F0,80,F0 with d_idx 0..4; d_done in cycle 7.
- Write burst d_addr=0x300, d_len=2, d_wdata=idx*0x11 → mem[0x300..0x302]=00,11,22; d_done in cycle 4; readback matches.
- fetch_req and d_req both rise same cycle after reset → fetch served first, data next. Repeat both → data served first (round-robin alternates).
- With CHIP8_FONT_PROTECT_EN: write burst d_addr=0x04E, d_len=3 → mem[0x04E,0x04F] unchanged, mem[0x050,0x051] written, d_prot_err=1 with d_done. Separately, assert rst_n low mid-write-burst → outputs at reset values, no d_done.
